esg_tracker: RTL and testbench
==============================

# esg_tracker

N-channel end-signal generator with qualification and handshake. Monitors the zero flags of `NUM_PU` processing units and declares completion when exactly one unit remains non-zero for `STABLE_CYCLES` consecutive valid samples. On completion it latches the surviving unit's index and holds `end_signal` until the controller acknowledges. It also detects and reports the illegal all-zero condition. It sits between the PU array and the top-level controller.

## Interface
- `NUM_PU`, 4, number of monitored processing units (≥2)
- `STABLE_CYCLES`, 1, consecutive qualifying samples required before completion (1..15)
- `IDX_W`, $clog2(NUM_PU), width of winner index (derived, not overridden)
- `clk` input 1 — single clock, rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `start` input 1 — begin a monitoring run
- `pu_valid` input 1 — `pu_zero` is meaningful this cycle
- `pu_zero` input NUM_PU — bit i = 1 when PU i's value is zero
- `ack` input 1 — controller acknowledges DONE or ERR
- `busy` output 1 — high in RUN
- `end_signal` output 1 — high in DONE
- `end_pulse` output 1 — one-cycle pulse on the first DONE cycle
- `all_zero_err` output 1 — high in ERR
- `winner_idx` output IDX_W — index of the single non-zero PU, latched on completion
- `cycle_count` output 16 — RUN cycles elapsed in the current or last run, saturating

## Operation
- Reset: state = IDLE; every output is 0; the stability counter is 0.
- Each sample is classified as one of:
  - ONE: exactly one `pu_zero` bit is 0. `~pu_zero` is one-hot.
  - NONE: all bits are 1.
  - MANY: otherwise.
- IDLE:
  - `start` → RUN. Clears `cycle_count`, the stability counter and `winner_idx`.
- RUN:
  - `cycle_count` increments every cycle and saturates at 16'hFFFF.
  - `pu_valid`=0: the stability counter holds.
  - `pu_valid`=1 with ONE: the counter increments. When the post-increment value equals `STABLE_CYCLES` → DONE, and `winner_idx` latches the position of the 0 bit.
  - `pu_valid`=1 with MANY: the counter clears to 0.
  - `pu_valid`=1 with NONE: → ERR, regardless of the counter.
  - `start` in RUN: restart. Counters clear, state stays RUN, and that cycle's sample is ignored.
- DONE: `end_signal`=1. `ack` → IDLE. `start` is ignored, including when asserted together with `ack`. `winner_idx` and `cycle_count` hold until the next `start`.
- ERR: `all_zero_err`=1. `ack` → IDLE. `start` is ignored.
- `ack` in IDLE or RUN is ignored.
- Asynchronous `rst_n` assertion mid-run: immediate return to IDLE, with all outputs cleared within the same cycle.
- The ONE classification requires a strict one-hot check. Two or more non-zero PUs never qualify, even when some bits are unknown-free.

## Timing
- All state and outputs are registered. There is no combinational path from inputs to outputs.
- `busy` rises the cycle after the `start` edge.
- Latency: with `STABLE_CYCLES`=K, `end_signal` and `end_pulse` rise in the cycle after the edge that samples the K-th consecutive qualifying ONE.
  - Minimum: K+1 cycles from the `start` edge when `pu_valid` is held high with ONE from the first RUN cycle.
- `end_pulse` is high for exactly one cycle per completion.
- `all_zero_err` rises the cycle after the NONE sample.
- DONE/ERR → IDLE takes one cycle after the `ack` edge. `end_signal`/`all_zero_err` fall in that cycle.
- `winner_idx` is stable from the first DONE cycle until the next `start`.
- Invalid cycles (`pu_valid`=0) between qualifying samples do not break consecutiveness. A MANY sample does.

## Test plan
- NUM_PU=4, K=1: `start`, then `pu_zero`=4'b1011 with `pu_valid`=1 → `end_signal`=1 and `end_pulse`=1 two cycles after `start`; `winner_idx`=2. `ack` → IDLE and `end_signal`=0 one cycle later.
- NUM_PU=4, K=3: sequence ONE, ONE, MANY(4'b0011), ONE, invalid, ONE, ONE → completion only after the final sample; `winner_idx` matches the last ONE pattern.
- NUM_PU=8, K=2: `pu_zero`=8'hFF while valid → `all_zero_err`=1 and `end_signal`=0; `ack` clears it; `start`+`ack` in ERR → IDLE, not RUN.
- Reset mid-run: assert `rst_n`=0 two cycles after `start` → all outputs are 0 immediately; after release, the block stays in IDLE until `start`.
- `cycle_count`: hold MANY for 70000 cycles → `cycle_count`=16'hFFFF and no wrap. `start` in RUN → `cycle_count` restarts at 0 with `busy` held high.

Source files
------------

// File: rtl/esg_tracker.sv
// End-signal generator: watches NUM_PU zero flags and reports when exactly one
// unit stays non-zero for STABLE_CYCLES valid samples, or when all units are zero.
module esg_tracker #(
    parameter int NUM_PU        = 4,
    parameter int STABLE_CYCLES = 1,
    localparam int IDX_W        = $clog2(NUM_PU)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pu_valid,
    input  logic [NUM_PU-1:0] pu_zero,
    input  logic              ack,
    output logic              busy,
    output logic              end_signal,
    output logic              end_pulse,
    output logic              all_zero_err,
    output logic [IDX_W-1:0]  winner_idx,
    output logic [15:0]       cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [3:0]        STAB_K = 4'(STABLE_CYCLES);
    localparam logic [NUM_PU-1:0] LSB_V  = {{(NUM_PU-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [3:0]         stab_q, stab_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic               pulse_q, pulse_d;

    logic [NUM_PU-1:0]  nonzero;
    logic               smp_none;
    logic               smp_one;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [IDX_W-1:0] zero_pos(input logic [NUM_PU-1:0] pz);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_PU; i++) begin
            if (!pz[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Strict one-hot test on the non-zero mask: nonzero and a single bit set.
    assign nonzero  = ~pu_zero;
    assign smp_none = (nonzero == '0);
    assign smp_one  = !smp_none && ((nonzero & (nonzero - LSB_V)) == '0);

    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        pulse_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    stab_d  = '0;
                    cnt_d   = '0;
                    win_d   = '0;
                end
            end
            S_RUN: begin
                cnt_d = sat_inc16(cnt_q);
                if (start) begin
                    // Restart: the sample presented alongside start is dropped.
                    stab_d = '0;
                    cnt_d  = '0;
                    win_d  = '0;
                end else if (pu_valid) begin
                    if (smp_none) begin
                        state_d = S_ERR;
                    end else if (smp_one) begin
                        stab_d = stab_q + 4'd1;
                        if (stab_q + 4'd1 == STAB_K) begin
                            state_d = S_DONE;
                            win_d   = zero_pos(pu_zero);
                            pulse_d = 1'b1;
                        end
                    end else begin
                        stab_d = '0;
                    end
                end
            end
            S_DONE, S_ERR: begin
                if (ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stab_q  <= '0;
            cnt_q   <= '0;
            win_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            pulse_q <= pulse_d;
        end
    end

    assign busy         = (state_q == S_RUN);
    assign end_signal   = (state_q == S_DONE);
    assign all_zero_err = (state_q == S_ERR);
    assign end_pulse    = pulse_q;
    assign winner_idx   = win_q;
    assign cycle_count  = cnt_q;

endmodule

// File: tb/tb_esg_tracker.sv
// Directed bench for esg_tracker: three instances (4/K=1, 4/K=3, 8/K=2)
// exercised one after another with hand-computed expectations.
module tb_esg_tracker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: NUM_PU=4, K=1
    logic a_start = 0, a_valid = 0, a_ack = 0;
    logic [3:0] a_pz = 4'hF;
    logic a_busy, a_end, a_pulse, a_err;
    logic [1:0] a_win;
    logic [15:0] a_cnt;

    // Instance B: NUM_PU=4, K=3
    logic b_start = 0, b_valid = 0, b_ack = 0;
    logic [3:0] b_pz = 4'hF;
    logic b_busy, b_end, b_pulse, b_err;
    logic [1:0] b_win;
    logic [15:0] b_cnt;

    // Instance C: NUM_PU=8, K=2
    logic c_start = 0, c_valid = 0, c_ack = 0;
    logic [7:0] c_pz = 8'hFF;
    logic c_busy, c_end, c_pulse, c_err;
    logic [2:0] c_win;
    logic [15:0] c_cnt;

    esg_tracker #(.NUM_PU(4), .STABLE_CYCLES(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .pu_valid(a_valid), .pu_zero(a_pz),
        .ack(a_ack), .busy(a_busy), .end_signal(a_end), .end_pulse(a_pulse),
        .all_zero_err(a_err), .winner_idx(a_win), .cycle_count(a_cnt));

    esg_tracker #(.NUM_PU(4), .STABLE_CYCLES(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .pu_valid(b_valid), .pu_zero(b_pz),
        .ack(b_ack), .busy(b_busy), .end_signal(b_end), .end_pulse(b_pulse),
        .all_zero_err(b_err), .winner_idx(b_win), .cycle_count(b_cnt));

    esg_tracker #(.NUM_PU(8), .STABLE_CYCLES(2)) u_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .pu_valid(c_valid), .pu_zero(c_pz),
        .ack(c_ack), .busy(c_busy), .end_signal(c_end), .end_pulse(c_pulse),
        .all_zero_err(c_err), .winner_idx(c_win), .cycle_count(c_cnt));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n active edges and settle 1 time unit past the last one.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_a_outs", {a_busy, a_end, a_pulse, a_err, a_win, a_cnt}, 0);
        chk("rst_c_outs", {c_busy, c_end, c_pulse, c_err, c_win, c_cnt}, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_a_busy", a_busy, 0);

        // A (K=1): immediate ONE -> done two cycles after start
        a_start = 1; a_valid = 1; a_pz = 4'b1011;
        tick();
        chk("a_busy_rise", a_busy, 1);
        chk("a_end_early", a_end, 0);
        a_start = 0;
        tick();
        chk("a_end", a_end, 1);
        chk("a_pulse", a_pulse, 1);
        chk("a_win", a_win, 2);
        chk("a_busy_done", a_busy, 0);
        chk("a_cnt_done", a_cnt, 1);
        a_valid = 0;
        tick();
        chk("a_pulse_once", a_pulse, 0);
        chk("a_end_hold", a_end, 1);
        a_ack = 1; a_start = 1;
        tick();
        chk("a_ack_end", a_end, 0);
        chk("a_ack_startign", a_busy, 0);
        chk("a_win_hold", a_win, 2);
        a_ack = 0; a_start = 0;
        tick();
        chk("a_idle_stays", a_busy, 0);

        // B (K=3): MANY breaks the streak, invalid cycles do not
        b_start = 1;
        tick();
        b_start = 0; b_valid = 1;
        b_pz = 4'b1110; tick(); chk("b_one1", b_end, 0);
        b_pz = 4'b1110; tick(); chk("b_one2", b_end, 0);
        b_pz = 4'b0011; tick(); chk("b_many", b_end, 0);
        b_pz = 4'b0111; tick(); chk("b_one_a", b_end, 0);
        b_valid = 0; b_pz = 4'b0000; tick(); chk("b_inv", b_end, 0);
        b_valid = 1; b_pz = 4'b0111; tick(); chk("b_one_b", b_end, 0);
        chk("b_busy_mid", b_busy, 1);
        b_pz = 4'b0111; tick();
        chk("b_end", b_end, 1);
        chk("b_pulse", b_pulse, 1);
        chk("b_win", b_win, 3);
        chk("b_cnt", b_cnt, 7);
        b_valid = 0; b_ack = 1;
        tick();
        chk("b_ack", {b_end, b_busy}, 0);
        b_ack = 0;

        // C (K=2): all-zero -> ERR; start+ack in ERR returns to IDLE
        c_start = 1;
        tick();
        c_start = 0; c_valid = 1; c_pz = 8'hFF;
        tick();
        chk("c_err", c_err, 1);
        chk("c_err_noend", c_end, 0);
        chk("c_err_nobusy", c_busy, 0);
        c_valid = 0; c_ack = 1; c_start = 1;
        tick();
        chk("c_err_clr", c_err, 0);
        chk("c_err_to_idle", c_busy, 0);
        c_ack = 0; c_start = 0;
        tick();
        chk("c_idle_stays", c_busy, 0);

        // C: ack in RUN ignored, then two qualifying samples
        c_start = 1;
        tick();
        c_start = 0; c_ack = 1;
        tick();
        chk("c_ack_run", c_busy, 1);
        c_ack = 0; c_valid = 1; c_pz = 8'b1111_0111;
        tick();
        chk("c_one1", c_end, 0);
        tick();
        chk("c_end", c_end, 1);
        chk("c_win", c_win, 3);
        c_valid = 0; c_ack = 1;
        tick();
        c_ack = 0;

        // Reset mid-run on A
        a_start = 1;
        tick();
        a_start = 0;
        tick();
        chk("a_pre_rst_busy", a_busy, 1);
        chk("a_pre_rst_cnt", a_cnt, 1);
        rst_n = 0;
        #1;
        chk("a_rst_outs", {a_busy, a_end, a_pulse, a_err, a_win, a_cnt}, 0);
        chk("c_rst_win", c_win, 0);
        tick();
        rst_n = 1;
        tick(3);
        chk("a_rst_idle", a_busy, 0);

        // B: cycle_count saturation and restart
        b_start = 1;
        tick();
        b_start = 0; b_valid = 1; b_pz = 4'b0011;
        tick(10);
        chk("b_cnt10", b_cnt, 10);
        tick(65530);
        chk("b_cnt_sat", b_cnt, 16'hFFFF);
        chk("b_sat_busy", b_busy, 1);
        tick();
        chk("b_cnt_nowrap", b_cnt, 16'hFFFF);
        b_start = 1;
        tick();
        chk("b_restart_cnt", b_cnt, 0);
        chk("b_restart_busy", b_busy, 1);
        b_start = 0;
        tick();
        chk("b_restart_cnt1", b_cnt, 1);
        b_pz = 4'b1111;
        tick();
        chk("b_err", b_err, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
